fp32_div: RTL and testbench



---
 rtl/fp32_pkg.sv | 45 ++++
 rtl/mant_div24.sv | 63 ++++++
 rtl/fp32_div.sv | 88 ++++++++
 tb/tb_fp32_div.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared FP32 constants, divider FSM states and the divider's result packing function.
package fp32_pkg;

    localparam int unsigned FP32_BIAS    = 127;
    localparam logic [7:0]  FP32_EXP_INF = 8'hFF;
    localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;
    localparam int unsigned DIV_ITERS    = 25;

    typedef enum logic [1:0] {StIdle, StDiv, StPack} div_state_e;

    // Returns {div_by_zero, y}; q is floor(a_mant * 2^24 / b_mant), so q[24] or q[23] is set.
    function automatic logic [32:0] fp32_div_pack(
        input logic              sign,
        input logic              a_zero,
        input logic              b_zero,
        input logic signed [9:0] exp,
        input logic [24:0]       q
    );
        logic signed [9:0] exp_n;
        logic [22:0]       frac;
        logic [32:0]       res;
        if (q[24]) begin
            frac  = q[23:1];
            exp_n = exp;
        end else begin
            frac  = q[22:0];
            exp_n = exp - 10'sd1;
        end
        if (a_zero && b_zero) begin
            res = {1'b1, FP32_QNAN};
        end else if (b_zero) begin
            res = {1'b1, sign, FP32_EXP_INF, 23'h0};
        end else if (a_zero) begin
            res = {1'b0, sign, 31'h0};
        end else if (exp_n >= 10'sd255) begin
            res = {1'b0, sign, FP32_EXP_INF, 23'h0};
        end else if (exp_n <= 10'sd0) begin
            res = {1'b0, sign, 31'h0};
        end else begin
            res = {1'b0, sign, exp_n[7:0], frac};
        end
        return res;
    endfunction

endpackage

// File: rtl/mant_div24.sv
// Restoring 24-bit mantissa divider: one quotient bit per cycle, DIV_ITERS bits in total.
module mant_div24
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [23:0] a_mant_i,
    input  logic [23:0] b_mant_i,
    output logic [24:0] q_o,
    output logic        done_o
);

    logic [24:0] r_q, r_d;
    logic [24:0] q_q, q_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        q_bit;
    logic [23:0] diff;

    // R < 2*b_mant always holds, so the remainder after subtraction fits in 24 bits.
    assign q_bit = (r_q >= {1'b0, b_mant_i});
    assign diff  = q_bit ? (r_q[23:0] - b_mant_i) : r_q[23:0];

    always_comb begin
        r_d    = r_q;
        q_d    = q_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start_i) begin
            r_d    = {1'b0, a_mant_i};
            q_d    = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            r_d   = {diff, 1'b0};
            q_d   = {q_q[23:0], q_bit};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(DIV_ITERS - 1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= '0;
            q_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            r_q    <= r_d;
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    // High during the cycle whose closing edge performs the last iteration.
    assign done_o = busy_q && (cnt_q == 5'(DIV_ITERS - 1));
    assign q_o    = q_q;

endmodule

// File: rtl/fp32_div.sv
// Iterative FP32 divider y = a / b: FTZ, truncation, fixed 26-cycle latency, one op in flight.
module fp32_div
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    output logic        ready_in,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        valid_out,
    output logic [31:0] y,
    output logic        div_by_zero
);

    div_state_e        state_q;
    logic              sign_q;
    logic              a_zero_q;
    logic              b_zero_q;
    logic signed [9:0] exp_q;
    logic [23:0]       b_mant_q;
    logic [31:0]       y_q;
    logic              dbz_q;
    logic              valid_q;
    logic              accept;
    logic              done;
    logic [24:0]       q;
    logic signed [9:0] exp_in;

    assign ready_in = (state_q == StIdle);
    assign accept   = valid_in && ready_in;
    assign exp_in   = $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]})
                    + $signed(10'(FP32_BIAS));

    mant_div24 u_mant_div24 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (accept),
        .a_mant_i ({1'b1, a[22:0]}),
        .b_mant_i (b_mant_q),
        .q_o      (q),
        .done_o   (done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            sign_q   <= 1'b0;
            a_zero_q <= 1'b0;
            b_zero_q <= 1'b0;
            exp_q    <= '0;
            b_mant_q <= '0;
            y_q      <= '0;
            dbz_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        sign_q   <= a[31] ^ b[31];
                        a_zero_q <= (a[30:23] == 8'h00);
                        b_zero_q <= (b[30:23] == 8'h00);
                        exp_q    <= exp_in;
                        b_mant_q <= {1'b1, b[22:0]};
                        state_q  <= StDiv;
                    end
                end
                StDiv: begin
                    if (done) begin
                        state_q <= StPack;
                    end
                end
                StPack: begin
                    {dbz_q, y_q} <= fp32_div_pack(sign_q, a_zero_q, b_zero_q, exp_q, q);
                    valid_q      <= 1'b1;
                    state_q      <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign valid_out   = valid_q;
    assign y           = y_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fp32_div.sv
// Self-checking bench for fp32_div: vector table, scoreboard with latency/handshake checks, reset abort.
module tb_fp32_div;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic        ready_in;
    logic [31:0] a;
    logic [31:0] b;
    logic        valid_out;
    logic [31:0] y;
    logic        div_by_zero;

    fp32_div dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_in    (valid_in),
        .ready_in    (ready_in),
        .a           (a),
        .b           (b),
        .valid_out   (valid_out),
        .y           (y),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic        dbz;
    } vec_t;

    typedef struct {
        logic [31:0] y;
        logic        dbz;
        int          acc;
    } sb_t;

    sb_t         sb[$];
    vec_t        vecs[10];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          done_cnt = 0;
    bit          use_force = 0;
    logic [32:0] force_exp;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Independent reference: exact integer quotient, then the same FTZ/truncate/clamp rules.
    function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] z);
        logic            s;
        int              ex, ez, e;
        longint unsigned num, den, qq;
        logic [22:0]     frac;
        s  = x[31] ^ z[31];
        ex = int'(x[30:23]);
        ez = int'(z[30:23]);
        if (ex == 0 && ez == 0) return {1'b1, 32'h7FC0_0000};
        if (ez == 0) return {1'b1, s, 8'hFF, 23'h0};
        if (ex == 0) return {1'b0, s, 31'h0};
        num = {40'h0, 1'b1, x[22:0]} << 24;
        den = {40'h0, 1'b1, z[22:0]};
        qq  = num / den;
        e   = ex - ez + 127;
        if (qq >= 64'h100_0000) begin
            frac = qq[23:1];
        end else begin
            frac = qq[22:0];
            e    = e - 1;
        end
        if (e >= 255) return {1'b0, s, 8'hFF, 23'h0};
        if (e <= 0) return {1'b0, s, 31'h0};
        return {1'b0, s, 8'(e), frac};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        sb_t  e;
        logic [32:0] m;
        if (rst_n) begin
            if (valid_out) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_valid_out", 32'(valid_out), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("y", y, e.y);
                    chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                    chk("latency", 32'(cyc - e.acc), 32'd26);
                    chk("ready_with_valid", 32'(ready_in), 32'd1);
                end
            end else if (sb.size() != 0 && cyc >= sb[0].acc) begin
                chk("ready_low_busy", 32'(ready_in), 32'd0);
                if (cyc - sb[0].acc > 27) begin
                    chk("result_timeout", 32'(cyc - sb[0].acc), 32'd26);
                    void'(sb.pop_front());
                end
            end
            if (valid_in && ready_in) begin
                acc_cnt++;
                m = use_force ? force_exp : model(a, b);
                sb.push_back('{y: m[31:0], dbz: m[32], acc: cyc + 1});
            end
        end
    end

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tbv, input logic [32:0] e);
        int n;
        @(posedge clk);
        #2;
        n = 0;
        while (!ready_in && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        use_force = 1;
        force_exp = e;
        valid_in  = 1'b1;
        a         = ta;
        b         = tbv;
        @(posedge clk);
        #2;
        valid_in  = 1'b0;
        use_force = 0;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("run_op_timeout", 32'(n), 32'd27);
            sb.delete();
        end
    endtask

    initial begin
        int a0, d0;
        vecs[0] = '{32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0};
        vecs[1] = '{32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 1'b0};
        vecs[2] = '{32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1'b1};
        vecs[3] = '{32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b1};
        vecs[4] = '{32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 1'b0};
        vecs[5] = '{32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 1'b0};
        vecs[6] = '{32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[7] = '{32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 1'b0};
        vecs[8] = '{32'hC0F0_0000, 32'h4020_0000, 32'hC040_0000, 1'b0};
        vecs[9] = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0};

        rst_n    = 1'b0;
        valid_in = 1'b0;
        a        = '0;
        b        = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        chk("rst_y", y, 32'h0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        chk("rst_ready_in", 32'(ready_in), 32'd1);
        @(negedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, {vecs[i].dbz, vecs[i].y});
        end
        repeat (3) @(posedge clk);
        #2;
        chk("y_hold", y, vecs[9].y);
        chk("valid_idle_low", 32'(valid_out), 32'd0);

        // Continuous valid_in with fresh operands every cycle.
        a0 = acc_cnt;
        d0 = done_cnt;
        for (int i = 0; i < 60; i++) begin
            valid_in = 1'b1;
            a        = $urandom;
            b        = $urandom;
            @(posedge clk);
            #2;
        end
        valid_in = 1'b0;
        chk("window_accepts", 32'(acc_cnt - a0), 32'd3);
        chk("window_completions", 32'(done_cnt - d0), 32'd2);
        begin
            int n;
            n = 0;
            while (sb.size() != 0 && n < 60) begin
                @(posedge clk);
                n++;
            end
            chk("window_drain", 32'(sb.size()), 32'd0);
            sb.delete();
        end

        // Reset in the middle of an op aborts it with no later result.
        run_op(vecs[3].a, vecs[3].b, {vecs[3].dbz, vecs[3].y});
        @(posedge clk);
        #2;
        use_force = 1;
        force_exp = {vecs[0].dbz, vecs[0].y};
        valid_in  = 1'b1;
        a         = vecs[0].a;
        b         = vecs[0].b;
        @(posedge clk);
        #2;
        valid_in  = 1'b0;
        use_force = 0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midrst_valid_out", 32'(valid_out), 32'd0);
        chk("midrst_y", y, 32'h0);
        chk("midrst_dbz", 32'(div_by_zero), 32'd0);
        chk("midrst_ready_in", 32'(ready_in), 32'd1);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        d0 = done_cnt;
        repeat (40) @(posedge clk);
        chk("no_stale_valid", 32'(done_cnt - d0), 32'd0);
        run_op(vecs[0].a, vecs[0].b, {vecs[0].dbz, vecs[0].y});
        chk("post_rst_result_count", 32'(done_cnt - d0), 32'd1);

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
